// File: rtl/cpu_ctrl_seq.sv
// cpu_ctrl_seq: hardwired fetch/execute control sequencer for the 32-bit bus CPU.
// Defining CTRL_SINGLE_STEP_EN adds a step_req input that gates each instruction start.
module cpu_ctrl_seq #(
   parameter int unsigned MEM_WAIT = 0,
   parameter int unsigned DIV_WAIT = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        run,
`ifdef CTRL_SINGLE_STEP_EN
   input  logic        step_req,
`endif
   input  logic [31:0] ir,
   input  logic        con_ff,
   output logic        PCout, IncPC, MARin, MDRin, MDRout, Read, write_mem, IRin, PCin, PCSave,
   output logic        Gra, Grb, Grc, Rin, Rout, BAout, Cout,
   output logic        Yin, Zin, Zlowout, Zhighout, HIin, LOin, HIout, LOout, CONin, INout,
   output logic        OUT_Portin,
   output logic [12:0] alu_op,
   output logic [2:0]  step,
   output logic        halted,
   output logic        illegal_op
);

   localparam logic [3:0] StIdle = 4'd0, StT0 = 4'd1, StT1 = 4'd2, StT2 = 4'd3, StT3 = 4'd4,
                          StT4 = 4'd5, StT5 = 4'd6, StT6 = 4'd7, StT7 = 4'd8, StHalt = 4'd9;

   localparam logic [12:0] OpAnd = 13'h0001, OpOr = 13'h0002, OpAdd = 13'h0004,
                           OpSub = 13'h0008, OpMul = 13'h0010, OpDiv = 13'h0020,
                           OpShr = 13'h0040, OpShra = 13'h0080, OpShl = 13'h0100,
                           OpRor = 13'h0200, OpRol = 13'h0400, OpNeg = 13'h0800,
                           OpNot = 13'h1000;

   localparam logic [4:0] OpcHalt = 5'd27;
   localparam logic [5:0] MemWaitN = 6'(MEM_WAIT);
   localparam logic [5:0] DivWaitN = 6'(DIV_WAIT);

   logic [3:0] state_q, state_d;
   logic [5:0] cnt_q, cnt_d;
   logic [4:0] opc_q, opc_d;
   logic       go;
   logic       unused_ir;

   assign unused_ir = ^ir[26:0];

`ifdef CTRL_SINGLE_STEP_EN
   logic step_req_q;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) step_req_q <= 1'b0;
      else        step_req_q <= step_req;
   end
   assign go = run & step_req & ~step_req_q;
`else
   assign go = run;
`endif

   function automatic logic [3:0] last_state(input logic [4:0] o);
      case (o) inside
         5'd0, 5'd2:                    last_state = StT7;
         5'd15, 5'd16, 5'd19:           last_state = StT6;
         5'd1, [5'd3:5'd14]:            last_state = StT5;
         5'd17, 5'd18, 5'd21:           last_state = StT4;
         default:                       last_state = StT3;
      endcase
   endfunction

   // Extra cycles a step is held; loaded into the counter on entry to that step.
   function automatic logic [5:0] wait_len(input logic [3:0] s, input logic [4:0] o);
      if (s == StT1 || (s == StT6 && o == 5'd0)) wait_len = MemWaitN;
      else if (s == StT4 && o == 5'd15)          wait_len = DivWaitN;
      else                                       wait_len = 6'd0;
   endfunction

   function automatic logic [12:0] alu_code(input logic [4:0] o);
      case (o)
         5'd3, 5'd12:  alu_code = OpAdd;
         5'd4:         alu_code = OpSub;
         5'd5, 5'd13:  alu_code = OpAnd;
         5'd6, 5'd14:  alu_code = OpOr;
         5'd7:         alu_code = OpRor;
         5'd8:         alu_code = OpRol;
         5'd9:         alu_code = OpShr;
         5'd10:        alu_code = OpShra;
         5'd11:        alu_code = OpShl;
         5'd15:        alu_code = OpDiv;
         5'd16:        alu_code = OpMul;
         5'd17:        alu_code = OpNeg;
         5'd18:        alu_code = OpNot;
         default:      alu_code = 13'h0000;
      endcase
   endfunction

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      opc_d   = opc_q;
      case (state_q)
         StIdle: if (go) state_d = StT0;
         StHalt: state_d = StHalt;
         default: begin
            if (cnt_q != 6'd0) begin
               cnt_d = cnt_q - 6'd1;
            end else if (state_q == StT3 && opc_q == OpcHalt) begin
               state_d = StHalt;
            end else if (state_q == last_state(opc_q)) begin
               state_d = go ? StT0 : StIdle;
            end else begin
               state_d = state_q + 4'd1;
               cnt_d   = wait_len(state_q + 4'd1, opc_q);
            end
            // IR is loaded at the end of T2; the opcode is frozen here for the execute steps.
            if (state_q == StT2) opc_d = ir[31:27];
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         cnt_q   <= 6'd0;
         opc_q   <= 5'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         opc_q   <= opc_d;
      end
   end

   always_comb begin
      {PCout, IncPC, MARin, MDRin, MDRout, Read, write_mem, IRin, PCin, PCSave} = '0;
      {Gra, Grb, Grc, Rin, Rout, BAout, Cout} = '0;
      {Yin, Zin, Zlowout, Zhighout, HIin, LOin, HIout, LOout, CONin, INout, OUT_Portin} = '0;
      alu_op     = 13'h0000;
      halted     = 1'b0;
      illegal_op = 1'b0;
      step       = (state_q >= StT0 && state_q <= StT7) ? 3'(state_q - 4'd1) : 3'd0;
      case (state_q)
         StIdle: ;
         StHalt: halted = 1'b1;
         StT0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; alu_op = OpAdd; end
         StT1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
         StT2: begin MDRout = 1'b1; IRin = 1'b1; end
         default: begin
            case (opc_q) inside
               [5'd0:5'd2]: begin
                  if (state_q == StT3) begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                  if (state_q == StT4) begin Cout = 1'b1; alu_op = OpAdd; Zin = 1'b1; end
                  if (state_q == StT5) begin
                     Zlowout = 1'b1;
                     MARin   = (opc_q != 5'd1);
                     Gra     = (opc_q == 5'd1);
                     Rin     = (opc_q == 5'd1);
                  end
                  if (state_q == StT6 && opc_q == 5'd0) begin Read = 1'b1; MDRin = 1'b1; end
                  if (state_q == StT6 && opc_q == 5'd2) begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
                  if (state_q == StT7 && opc_q == 5'd0) begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                  if (state_q == StT7 && opc_q == 5'd2) write_mem = 1'b1;
               end
               [5'd3:5'd14]: begin
                  if (state_q == StT3) begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                  if (state_q == StT4) begin
                     Grc    = (opc_q < 5'd12);
                     Rout   = (opc_q < 5'd12);
                     Cout   = (opc_q >= 5'd12);
                     alu_op = alu_code(opc_q);
                     Zin    = 1'b1;
                  end
                  if (state_q == StT5) begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
               end
               5'd15, 5'd16: begin
                  if (state_q == StT3) begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                  if (state_q == StT4) begin
                     Grb = 1'b1; Rout = 1'b1; alu_op = alu_code(opc_q); Zin = 1'b1;
                  end
                  if (state_q == StT5) begin Zlowout = 1'b1; LOin = 1'b1; end
                  if (state_q == StT6) begin Zhighout = 1'b1; HIin = 1'b1; end
               end
               5'd17, 5'd18: begin
                  if (state_q == StT3) begin
                     Grb = 1'b1; Rout = 1'b1; alu_op = alu_code(opc_q); Zin = 1'b1;
                  end
                  if (state_q == StT4) begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
               end
               5'd19: begin
                  if (state_q == StT3) begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
                  if (state_q == StT4) begin PCout = 1'b1; Yin = 1'b1; end
                  if (state_q == StT5) begin Cout = 1'b1; alu_op = OpAdd; Zin = 1'b1; end
                  if (state_q == StT6) begin Zlowout = 1'b1; PCin = con_ff; end
               end
               5'd20: if (state_q == StT3) begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
               5'd21: begin
                  if (state_q == StT3) begin PCout = 1'b1; PCSave = 1'b1; end
                  if (state_q == StT4) begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
               end
               5'd22: if (state_q == StT3) begin INout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
               5'd23: if (state_q == StT3) begin Gra = 1'b1; Rout = 1'b1; OUT_Portin = 1'b1; end
               5'd24, 5'd25: begin
                  if (state_q == StT3) begin
                     HIout = (opc_q == 5'd24);
                     LOout = (opc_q == 5'd25);
                     Gra   = 1'b1;
                     Rin   = 1'b1;
                  end
               end
               [5'd28:5'd31]: if (state_q == StT3) illegal_op = 1'b1;
               default: ;
            endcase
         end
      endcase
   end

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// tb_cpu_ctrl_seq: two sequencer instances (no waits, and MEM_WAIT=2/DIV_WAIT=5) checked
// cycle by cycle against a step-list model, plus latency table and corner-case sequences.
`timescale 1ns/1ps
module tb_cpu_ctrl_seq;
   typedef logic [45:0] vec_t;
   localparam int MW1 = 2;
   localparam int DW1 = 5;

   localparam vec_t PCOUT = vec_t'(1) << 0,  INCPC = vec_t'(1) << 1,  MARIN = vec_t'(1) << 2;
   localparam vec_t MDRIN = vec_t'(1) << 3,  MDROUT = vec_t'(1) << 4, READ = vec_t'(1) << 5;
   localparam vec_t WRMEM = vec_t'(1) << 6,  IRIN = vec_t'(1) << 7,   PCIN = vec_t'(1) << 8;
   localparam vec_t PCSAVE = vec_t'(1) << 9, GRA = vec_t'(1) << 10,   GRB = vec_t'(1) << 11;
   localparam vec_t GRC = vec_t'(1) << 12,   RIN = vec_t'(1) << 13,   ROUT = vec_t'(1) << 14;
   localparam vec_t BAOUT = vec_t'(1) << 15, COUT = vec_t'(1) << 16,  YIN = vec_t'(1) << 17;
   localparam vec_t ZIN = vec_t'(1) << 18,   ZLO = vec_t'(1) << 19,   ZHI = vec_t'(1) << 20;
   localparam vec_t HIIN = vec_t'(1) << 21,  LOIN = vec_t'(1) << 22,  HIOUT = vec_t'(1) << 23;
   localparam vec_t LOOUT = vec_t'(1) << 24, CONIN = vec_t'(1) << 25, INOUT = vec_t'(1) << 26;
   localparam vec_t OUTP = vec_t'(1) << 27,  HALTED = vec_t'(1) << 44, ILL = vec_t'(1) << 45;
   // ALU bit numbers: AND0 OR1 ADD2 SUB3 MUL4 DIV5 SHR6 SHRA7 SHL8 ROR9 ROL10 NEG11 NOT12
   localparam vec_t T0V = PCOUT | MARIN | INCPC | ZIN | (vec_t'(1) << 30);

   logic clk = 1'b0;
   logic reset, run, con_ff;
   logic [31:0] ir;
`ifdef CTRL_SINGLE_STEP_EN
   logic step_req = 1'b0;
`endif
   logic [27:0] s0, s1;
   logic [12:0] a0, a1;
   logic [2:0]  t0, t1;
   logic        h0, h1, i0, i1;
   vec_t        o0, o1;
   assign o0 = {i0, h0, t0, a0, s0};
   assign o1 = {i1, h1, t1, a1, s1};

   initial forever #5 clk = ~clk;

   cpu_ctrl_seq #(.MEM_WAIT(0), .DIV_WAIT(0)) dut0 (
      .clk(clk), .reset(reset), .run(run),
`ifdef CTRL_SINGLE_STEP_EN
      .step_req(step_req),
`endif
      .ir(ir), .con_ff(con_ff),
      .PCout(s0[0]), .IncPC(s0[1]), .MARin(s0[2]), .MDRin(s0[3]), .MDRout(s0[4]),
      .Read(s0[5]), .write_mem(s0[6]), .IRin(s0[7]), .PCin(s0[8]), .PCSave(s0[9]),
      .Gra(s0[10]), .Grb(s0[11]), .Grc(s0[12]), .Rin(s0[13]), .Rout(s0[14]),
      .BAout(s0[15]), .Cout(s0[16]), .Yin(s0[17]), .Zin(s0[18]), .Zlowout(s0[19]),
      .Zhighout(s0[20]), .HIin(s0[21]), .LOin(s0[22]), .HIout(s0[23]), .LOout(s0[24]),
      .CONin(s0[25]), .INout(s0[26]), .OUT_Portin(s0[27]),
      .alu_op(a0), .step(t0), .halted(h0), .illegal_op(i0)
   );

   cpu_ctrl_seq #(.MEM_WAIT(MW1), .DIV_WAIT(DW1)) dut1 (
      .clk(clk), .reset(reset), .run(run),
`ifdef CTRL_SINGLE_STEP_EN
      .step_req(step_req),
`endif
      .ir(ir), .con_ff(con_ff),
      .PCout(s1[0]), .IncPC(s1[1]), .MARin(s1[2]), .MDRin(s1[3]), .MDRout(s1[4]),
      .Read(s1[5]), .write_mem(s1[6]), .IRin(s1[7]), .PCin(s1[8]), .PCSave(s1[9]),
      .Gra(s1[10]), .Grb(s1[11]), .Grc(s1[12]), .Rin(s1[13]), .Rout(s1[14]),
      .BAout(s1[15]), .Cout(s1[16]), .Yin(s1[17]), .Zin(s1[18]), .Zlowout(s1[19]),
      .Zhighout(s1[20]), .HIin(s1[21]), .LOin(s1[22]), .HIout(s1[23]), .LOout(s1[24]),
      .CONin(s1[25]), .INout(s1[26]), .OUT_Portin(s1[27]),
      .alu_op(a1), .step(t1), .halted(h1), .illegal_op(i1)
   );

   int n_cmp = 0;
   int n_bad = 0;
   vec_t e0[$];
   vec_t e1[$];

   typedef struct {
      logic [4:0] op;
      logic       con;
      int         lat0;
      int         lat1;
   } rec_t;
   rec_t tbl[20];

   task automatic chk(input string name, input vec_t act, input vec_t exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic vec_t alu(input int b);
      return vec_t'(1) << (28 + b);
   endfunction

   function automatic int op_bit(input logic [4:0] op);
      case (op)
         5'd3, 5'd12: return 2;
         5'd4:        return 3;
         5'd5, 5'd13: return 0;
         5'd6, 5'd14: return 1;
         5'd7:        return 9;
         5'd8:        return 10;
         5'd9:        return 6;
         5'd10:       return 7;
         5'd11:       return 8;
         5'd15:       return 5;
         5'd16:       return 4;
         5'd17:       return 11;
         default:     return 12;
      endcase
   endfunction

   task automatic add(input int w, input int t, input vec_t s, input int reps);
      for (int r = 0; r < reps; r++) begin
         if (w == 0) e0.push_back(s | (vec_t'(t) << 41));
         else        e1.push_back(s | (vec_t'(t) << 41));
      end
   endtask

   // Expected per-cycle outputs of one instruction, straight from its step list.
   task automatic build(input int w, input logic [4:0] op, input logic con);
      int mw, dw;
      vec_t opv;
      mw  = (w == 0) ? 0 : MW1;
      dw  = (w == 0) ? 0 : DW1;
      opv = alu(op_bit(op));
      add(w, 0, T0V, 1);
      add(w, 1, ZLO | PCIN | READ | MDRIN, mw + 1);
      add(w, 2, MDROUT | IRIN, 1);
      case (op) inside
         [5'd0:5'd2]: begin
            add(w, 3, GRB | BAOUT | YIN, 1);
            add(w, 4, COUT | alu(2) | ZIN, 1);
            if (op == 5'd1) add(w, 5, ZLO | GRA | RIN, 1);
            else            add(w, 5, ZLO | MARIN, 1);
            if (op == 5'd0) begin
               add(w, 6, READ | MDRIN, mw + 1);
               add(w, 7, MDROUT | GRA | RIN, 1);
            end else if (op == 5'd2) begin
               add(w, 6, GRA | ROUT | MDRIN, 1);
               add(w, 7, WRMEM, 1);
            end
         end
         [5'd3:5'd11]: begin
            add(w, 3, GRB | ROUT | YIN, 1);
            add(w, 4, GRC | ROUT | opv | ZIN, 1);
            add(w, 5, ZLO | GRA | RIN, 1);
         end
         [5'd12:5'd14]: begin
            add(w, 3, GRB | ROUT | YIN, 1);
            add(w, 4, COUT | opv | ZIN, 1);
            add(w, 5, ZLO | GRA | RIN, 1);
         end
         5'd15, 5'd16: begin
            add(w, 3, GRA | ROUT | YIN, 1);
            add(w, 4, GRB | ROUT | opv | ZIN, (op == 5'd15) ? dw + 1 : 1);
            add(w, 5, ZLO | LOIN, 1);
            add(w, 6, ZHI | HIIN, 1);
         end
         5'd17, 5'd18: begin
            add(w, 3, GRB | ROUT | opv | ZIN, 1);
            add(w, 4, ZLO | GRA | RIN, 1);
         end
         5'd19: begin
            add(w, 3, GRA | ROUT | CONIN, 1);
            add(w, 4, PCOUT | YIN, 1);
            add(w, 5, COUT | alu(2) | ZIN, 1);
            add(w, 6, ZLO | (con ? PCIN : vec_t'(0)), 1);
         end
         5'd20: add(w, 3, GRA | ROUT | PCIN, 1);
         5'd21: begin
            add(w, 3, PCOUT | PCSAVE, 1);
            add(w, 4, GRA | ROUT | PCIN, 1);
         end
         5'd22: add(w, 3, INOUT | GRA | RIN, 1);
         5'd23: add(w, 3, GRA | ROUT | OUTP, 1);
         5'd24: add(w, 3, HIOUT | GRA | RIN, 1);
         5'd25: add(w, 3, LOOUT | GRA | RIN, 1);
         [5'd28:5'd31]: add(w, 3, ILL, 1);
         default: add(w, 3, vec_t'(0), 1);
      endcase
   endtask

   task automatic do_reset();
      reset = 1'b0;
      run   = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   // Start one instruction from IDLE with a one-cycle run pulse; both instances checked.
   task automatic run_instr(input logic [4:0] op, input logic con, input int lat0,
                            input int lat1, input bit dolat);
      int c0, c1;
      vec_t x0, x1;
      e0.delete();
      e1.delete();
      build(0, op, con);
      build(1, op, con);
      ir     = {op, 27'($urandom)};
      con_ff = con;
      run    = 1'b1;
      c0 = 0;
      c1 = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         run = 1'b0;
         x0 = (e0.size() > 0) ? e0.pop_front() : vec_t'(0);
         x1 = (e1.size() > 0) ? e1.pop_front() : vec_t'(0);
         chk($sformatf("op%0d dut0 cyc%0d", op, c + 1), o0, x0);
         chk($sformatf("op%0d dut1 cyc%0d", op, c + 1), o1, x1);
         if (o0 != 0) c0++;
         if (o1 != 0) c1++;
      end
      if (dolat) begin
         chk_int($sformatf("op%0d latency dut0", op), c0, lat0);
         chk_int($sformatf("op%0d latency dut1", op), c1, lat1);
      end
   endtask

   initial begin
      int r, rd1, rd6, nill;
      bit found;
      logic [4:0] op;
      logic [2:0] exp_steps [7];

      tbl[0]  = '{5'd0,  1'b0, 8, 12};  tbl[1]  = '{5'd1,  1'b0, 6, 8};
      tbl[2]  = '{5'd3,  1'b0, 6, 8};   tbl[3]  = '{5'd11, 1'b0, 6, 8};
      tbl[4]  = '{5'd12, 1'b0, 6, 8};   tbl[5]  = '{5'd14, 1'b0, 6, 8};
      tbl[6]  = '{5'd15, 1'b0, 7, 14};  tbl[7]  = '{5'd16, 1'b0, 7, 9};
      tbl[8]  = '{5'd25, 1'b0, 4, 6};   tbl[9]  = '{5'd17, 1'b0, 5, 7};
      tbl[10] = '{5'd18, 1'b0, 5, 7};   tbl[11] = '{5'd19, 1'b0, 7, 9};
      tbl[12] = '{5'd19, 1'b1, 7, 9};   tbl[13] = '{5'd20, 1'b0, 4, 6};
      tbl[14] = '{5'd21, 1'b0, 5, 7};   tbl[15] = '{5'd22, 1'b0, 4, 6};
      tbl[16] = '{5'd23, 1'b0, 4, 6};   tbl[17] = '{5'd24, 1'b0, 4, 6};
      tbl[18] = '{5'd26, 1'b0, 4, 6};   tbl[19] = '{5'd29, 1'b0, 4, 6};

      reset = 1'b0; run = 1'b0; ir = 32'h0; con_ff = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset dut0", o0, vec_t'(0));
      chk("reset dut1", o1, vec_t'(0));
      reset = 1'b1;
      @(negedge clk);
      chk("idle dut0", o0, vec_t'(0));

      foreach (tbl[k]) run_instr(tbl[k].op, tbl[k].con, tbl[k].lat0, tbl[k].lat1, 1'b1);

      for (int n = 0; n < 40; n++) begin
         r  = $urandom_range(0, 30);
         op = (r < 27) ? 5'(r) : 5'(r + 1);
         run_instr(op, 1'($urandom), 0, 0, 1'b0);
      end

      // ld with MEM_WAIT=2: Read held 3 cycles in T1 and in T6
      ir = 32'h0000_0000; run = 1'b1; rd1 = 0; rd6 = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         run = 1'b0;
         if (o1[5] && t1 == 3'd1) rd1++;
         if (o1[5] && t1 == 3'd6) rd6++;
      end
      chk_int("ld read cycles T1", rd1, 3);
      chk_int("ld read cycles T6", rd6, 3);

      // back-to-back ldi with run held, no wait states
      do_reset();
      exp_steps = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
      ir = 32'h0812_3456; run = 1'b1;
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         chk_int($sformatf("ldi step cyc%0d", c + 1), int'(t0), int'(exp_steps[c]));
         if (c == 5) chk("ldi cyc6", o0, ZLO | GRA | RIN | (vec_t'(5) << 41));
         if (c == 6) chk("ldi cyc7 T0", o0, T0V);
      end

      // illegal opcode pulse, next fetch, then halt with run held
      do_reset();
      ir = {5'd29, 27'h0}; run = 1'b1; nill = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (i0) nill++;
         if (c == 4) begin
            chk("post-illegal T0", o0, T0V);
            ir = {5'd27, 27'h0};
         end
      end
      chk_int("illegal pulse count", nill, 1);
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         chk($sformatf("halt cyc%0d", c + 1), o0, HALTED);
      end

      // asynchronous reset during the DIV wait step
      do_reset();
      ir = {5'd15, 27'h0}; run = 1'b1; found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
         @(negedge clk);
         run = 1'b0;
         if (t1 == 3'd4) found = 1'b1;
      end
      chk_int("div reached T4", int'(found), 1);
      @(negedge clk);
      chk_int("div still T4", int'(t1), 4);
      #2 reset = 1'b0;
      #1 chk("abort dut1", o1, vec_t'(0));
      chk("abort dut0", o0, vec_t'(0));
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("idle after abort", o1, vec_t'(0));
      run = 1'b1;
      @(negedge clk);
      run = 1'b0;
      chk("restart T0", o1, T0V);
      repeat (20) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
